// File: rtl/sa_activation_skew_feeder.sv
// Diagonal skew feeder for the systolic-array west edge: lane i trails lane 0 by i cycles.
// Tiles are separated by a drain window so the last row of one tile clears before the next enters.
module sa_activation_skew_feeder #(
  parameter int SA_SIZE                = 3,
  parameter int WEIGHT_ACTIVATION_SIZE = 8
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic                                           in_last,
  input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] in_data,
  output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] out_data,
  output logic [SA_SIZE-1:0]                             out_valid,
  output logic                                           out_last,
  output logic                                           busy
);

  localparam int CW = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = (SA_SIZE > 1) ? CW'(SA_SIZE - 2) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_drain_cnt;
  logic [CW-1:0]   w_drain_cnt_nxt;
  logic            w_accept;
  logic [SA_SIZE-1:0] w_lane_any;
  logic [SA_SIZE-1:0] r_last;

  assign in_ready = (r_state != DRAIN);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      IDLE, STREAM: begin
        if (w_accept) begin
          if (in_last) begin
            // A one-lane array has no skew, so there is nothing to drain.
            w_state_nxt     = (SA_SIZE == 1) ? IDLE : DRAIN;
            w_drain_cnt_nxt = '0;
          end else begin
            w_state_nxt = STREAM;
          end
        end
      end
      DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_nxt     = IDLE;
          w_drain_cnt_nxt = '0;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_drain_cnt_nxt = '0;
      end
    endcase
  end

  for (genvar i = 0; i < SA_SIZE; i++) begin : g_lane
    logic [i:0]                        r_v;
    logic [WEIGHT_ACTIVATION_SIZE-1:0] r_d [i+1];

    // Bubbles load zero data so out_data is clean whenever out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= '0;
        for (int s = 0; s <= i; s++) r_d[s] <= '0;
      end else begin
        r_v[0] <= w_accept;
        r_d[0] <= w_accept ? in_data[i] : '0;
        for (int s = 1; s <= i; s++) begin
          r_v[s] <= r_v[s-1];
          r_d[s] <= r_d[s-1];
        end
      end
    end

    assign out_valid[i]  = r_v[i];
    assign out_data[i]   = r_d[i];
    assign w_lane_any[i] = |r_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else if (SA_SIZE == 1) begin
      r_last <= w_accept && in_last;
    end else begin
      r_last <= {r_last[SA_SIZE-2:0], w_accept && in_last};
    end
  end

  assign out_last = r_last[SA_SIZE-1];
  assign busy     = (r_state != IDLE) || (|out_valid) || (|w_lane_any);

endmodule

// File: tb/tb_sa_activation_skew_feeder.sv
// Directed bench for the skew feeder: SA_SIZE=3 main instance plus an SA_SIZE=1 build.
module tb_sa_activation_skew_feeder;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [2:0][7:0]  in_data;
  logic [2:0][7:0]  out_data;
  logic [2:0]       out_valid;
  logic             out_last;
  logic             busy;

  logic             s_in_valid;
  logic             s_in_ready;
  logic             s_in_last;
  logic [0:0][7:0]  s_in_data;
  logic [0:0][7:0]  s_out_data;
  logic [0:0]       s_out_valid;
  logic             s_out_last;
  logic             s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sa_activation_skew_feeder #(.SA_SIZE(3), .WEIGHT_ACTIVATION_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .busy(busy)
  );

  sa_activation_skew_feeder #(.SA_SIZE(1), .WEIGHT_ACTIVATION_SIZE(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_last(s_in_last), .in_data(s_in_data),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_last(s_out_last), .busy(s_busy)
  );

  task automatic run_table(input string name, input int n,
                           input logic tv [8], input logic [23:0] td [8], input logic tl [8],
                           input logic [2:0] ev [8], input logic [23:0] ed [8],
                           input logic el [8], input logic er [8]);
    for (int k = 0; k < n; k++) begin
      in_valid = tv[k];
      in_data  = td[k];
      in_last  = tl[k];
      @(posedge clk); #1;
      checks++;
      if (out_valid !== ev[k]) begin
        errors++;
        $display("FAIL %s edge%0d out_valid got %b exp %b", name, k, out_valid, ev[k]);
      end
      checks++;
      if (out_data !== ed[k]) begin
        errors++;
        $display("FAIL %s edge%0d out_data got %h exp %h", name, k, out_data, ed[k]);
      end
      checks++;
      if (out_last !== el[k]) begin
        errors++;
        $display("FAIL %s edge%0d out_last got %b exp %b", name, k, out_last, el[k]);
      end
      checks++;
      if (in_ready !== er[k]) begin
        errors++;
        $display("FAIL %s edge%0d in_ready got %b exp %b", name, k, in_ready, er[k]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s final busy got %b exp 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_in_data = '0;
    #3;
    checks++;
    if ({out_valid, out_data, out_last, busy, in_ready} !== {3'b000, 24'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset got v=%b d=%h l=%b busy=%b rdy=%b exp v=0 d=0 l=0 busy=0 rdy=1",
               out_valid, out_data, out_last, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_row();
    logic tv [8] = '{1,0,0,0,0,0,0,0};
    logic [23:0] td [8] = '{24'h030201,0,0,0,0,0,0,0};
    logic tl [8] = '{1,0,0,0,0,0,0,0};
    logic [2:0] ev [8] = '{3'b001,3'b010,3'b100,3'b000,0,0,0,0};
    logic [23:0] ed [8] = '{24'h000001,24'h000200,24'h030000,24'h0,0,0,0,0};
    logic el [8] = '{0,0,1,0,0,0,0,0};
    logic er [8] = '{0,0,1,1,0,0,0,0};
    run_table("single_row", 4, tv, td, tl, ev, ed, el, er);
  endtask

  task automatic test_back_to_back();
    logic tv [8] = '{1,1,0,0,0,0,0,0};
    logic [23:0] td [8] = '{24'h030201,24'h060504,0,0,0,0,0,0};
    logic tl [8] = '{0,1,0,0,0,0,0,0};
    logic [2:0] ev [8] = '{3'b001,3'b011,3'b110,3'b100,3'b000,0,0,0};
    logic [23:0] ed [8] = '{24'h000001,24'h000204,24'h030500,24'h060000,24'h0,0,0,0};
    logic el [8] = '{0,0,0,1,0,0,0,0};
    logic er [8] = '{1,0,0,1,1,0,0,0};
    run_table("back_to_back", 5, tv, td, tl, ev, ed, el, er);
  endtask

  task automatic test_stall();
    logic tv [8] = '{1,0,1,0,0,0,0,0};
    logic [23:0] td [8] = '{24'h090807,24'hAAAAAA,24'h0C0B0A,0,0,0,0,0};
    logic tl [8] = '{0,1,1,0,0,0,0,0};
    logic [2:0] ev [8] = '{3'b001,3'b010,3'b101,3'b010,3'b100,3'b000,0,0};
    logic [23:0] ed [8] = '{24'h000007,24'h000800,24'h09000A,24'h000B00,24'h0C0000,24'h0,0,0};
    logic el [8] = '{0,0,0,0,1,0,0,0};
    logic er [8] = '{1,1,0,0,1,1,0,0};
    run_table("stall", 6, tv, td, tl, ev, ed, el, er);
  endtask

  task automatic test_drain_hold();
    logic tv [8] = '{1,1,1,1,0,0,0,0};
    logic [23:0] td [8] = '{24'h030201,24'h050505,24'h050505,24'h050505,0,0,0,0};
    logic tl [8] = '{1,1,1,1,0,0,0,0};
    logic [2:0] ev [8] = '{3'b001,3'b010,3'b100,3'b001,3'b010,3'b100,3'b000,0};
    logic [23:0] ed [8] = '{24'h000001,24'h000200,24'h030000,24'h000005,24'h000500,24'h050000,24'h0,0};
    logic el [8] = '{0,0,1,0,0,1,0,0};
    logic er [8] = '{0,0,1,0,0,1,1,0};
    run_table("drain_hold", 7, tv, td, tl, ev, ed, el, er);
  endtask

  task automatic test_reset_midflight();
    in_valid = 1'b1; in_last = 1'b0; in_data = 24'h030201;
    @(posedge clk); #1;
    in_data = 24'h060504;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
    checks++;
    if (out_valid !== 3'b011) begin
      errors++;
      $display("FAIL reset_mid pre out_valid got %b exp 011", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_last, busy, in_ready} !== {3'b000, 24'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid asserted got v=%b d=%h l=%b busy=%b rdy=%b exp 0/0/0/0/1",
               out_valid, out_data, out_last, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_data, out_last, busy, in_ready} !== {3'b000, 24'h0, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL reset_mid residue edge%0d got v=%b d=%h l=%b busy=%b rdy=%b exp 0/0/0/0/1",
                 k, out_valid, out_data, out_last, busy, in_ready);
      end
    end
  endtask

  task automatic test_size1();
    logic [7:0] rows [3] = '{8'h11, 8'h22, 8'h33};
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (s_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL size1 row%0d in_ready got %b exp 1", k, s_in_ready);
      end
      s_in_valid = 1'b1; s_in_last = 1'b1; s_in_data = rows[k];
      @(posedge clk); #1;
      checks++;
      if ({s_out_valid, s_out_data, s_out_last} !== {1'b1, rows[k], 1'b1}) begin
        errors++;
        $display("FAIL size1 row%0d got v=%b d=%h l=%b exp v=1 d=%h l=1",
                 k, s_out_valid, s_out_data, s_out_last, rows[k]);
      end
    end
    s_in_valid = 1'b0; s_in_last = 1'b0; s_in_data = '0;
    @(posedge clk); #1;
    checks++;
    if ({s_out_valid, s_out_data, s_out_last, s_busy, s_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL size1 idle got v=%b d=%h l=%b busy=%b rdy=%b exp 0/0/0/0/1",
               s_out_valid, s_out_data, s_out_last, s_busy, s_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_stall();
    test_drain_hold();
    test_reset_midflight();
    test_size1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
